mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX beside the 32-bit ALU and is fed the same ID/EX operands (a = rs value, b = rt value).
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. While `busy` is high it stalls the pipeline. MFHI/MFLO read `hi`/`lo` combinationally.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iteration cycles in CALC. Must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  operation request, sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress; pipeline stall request.
- done  output  1  one-cycle pulse; HI/LO are valid in the same cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock/reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`.
- Reset state: IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation: aborts the operation. No `done` pulse; HI/LO are cleared to 0.
- FSM states: IDLE, CALC, FIX.
- IDLE, `start`=1, op=MTHI or MTLO (edge E0):
  - hi := a (MTHI) or lo := a (MTLO).
  - `done`=1 for the cycle after E0; `busy` stays 0.
- IDLE, `start`=1, op=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch the operands. Signed ops latch absolute values plus the two sign bits.
  - Clear the counter, go to CALC, `busy`=1.
- IDLE, `start`=1, reserved op: ignored; no state change, no `done`.
- `start` while `busy`=1: ignored. Operands are only captured at E0.
- CALC: one iteration per cycle; the counter increments each cycle.
  - Multiply: shift-add with a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - After ITER cycles (edge E32) go to FIX.
- FIX (edge E33):
  - Apply sign correction.
    - Signed product is negated when the operand signs differ.
    - Quotient is negated when the signs differ.
    - Remainder takes the sign of the dividend.
  - Write HI/LO. For multiply, HI = product[63:32] and LO = product[31:0]. For divide, LO = quotient and HI = remainder.
  - `done`=1 and `busy`=0 for the cycle after E33; return to IDLE.
  - Total: `busy` high for exactly 33 cycles, with `done` in the first cycle after `busy` falls.
- Back-to-back: `start` asserted in the `done` cycle is accepted (the FSM is in IDLE).
- HI/LO hold their values while `busy`=1. The old values stay readable until the FIX write.
- Divide by zero, unsigned and signed: LO = 0xFFFFFFFF, HI = a. Full 33-cycle latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Absolute value of 0x80000000 is handled as unsigned 2^31. No internal overflow.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU go IDLE -> FIX directly, using a single-cycle 32x32 product.
  - `busy`=1 for one cycle; HI/LO are written and `done` pulses after edge E1.
  - DIV/DIVU are unchanged (33 cycles).
- Undefined: every multiply uses the 33-cycle iterative path described in Behaviour.

Test Plan:
- MULT a=0x00000007, b=0xFFFFFFFD -> after 33 busy cycles, `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MULDIV_FAST_MUL_EN, `done` one cycle after start.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Start handling:
  - MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated, `done` each cycle, `busy` never 1.
  - `start` with new operands in the middle of a MULT -> ignored; result matches the first operands.
  - Reserved op 3'b110 -> no `done`, HI/LO unchanged.
- Reset: drive `rst_n`=0 for one cycle at iteration 10 of a DIVU -> next cycle `busy`=0, hi=lo=0, no `done` pulse. Then `start` in the same cycle as `done` of a MULT -> the second op is accepted and completes 33 busy cycles later.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: 33-cycle shift-add multiply and restoring divide; busy stalls the pipe, done pulses once HI/LO are written.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply (MULT/MULTU go IDLE->FIX); divide is always iterative.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;

    logic               is_signed_op, sa, sb;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Magnitudes are taken as unsigned, so |0x80000000| is simply 2^31.
    assign is_signed_op = ~op[0];
    assign sa           = is_signed_op & a[WIDTH-1];
    assign sb           = is_signed_op & b[WIDTH-1];
    assign a_abs        = sa ? -a : a;
    assign b_abs        = sb ? -b : b;

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign div_ge   = (rem_sh >= {1'b0, opb});
    assign div_next = div_ge ? {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b100: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            3'b101: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div <= op[1];
                                neg_q  <= sa ^ sb;
                                neg_r  <= sa;
                                b_zero <= (b == '0);
                                cnt    <= '0;
                                busy   <= 1'b1;
                                if (op[1]) begin
                                    acc   <= {{WIDTH{1'b0}}, a_abs};
                                    opb   <= b_abs;
                                    state <= CALC;
                                end else begin
`ifdef MULDIV_FAST_MUL_EN
                                    acc   <= {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
                                    state <= FIX;
`else
                                    acc   <= {{WIDTH{1'b0}}, b_abs};
                                    opb   <= a_abs;
                                    state <= CALC;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        // Divide by zero leaves |a| as the remainder; restoring its sign returns a.
                        lo <= b_zero ? {WIDTH{1'b1}} : q_fix;
                        hi <= r_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: hand-computed HI/LO results, busy length and start/reset handling.
module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;
    int mul_lat;

    mips_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally poke start with other operands in the first busy cycle,
    // then count busy cycles (bounded) until it drops.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit interfere, input logic [31:0] hold_hi, output int cnt);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (interfere && cnt == 1) begin
                chk("hold_hi", hi, hold_hi);
                start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
`ifdef MULDIV_FAST_MUL_EN
        mul_lat = 1;
`else
        mul_lat = 33;
`endif
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MTHI then MTLO back to back
        start = 1'b1; op = 3'b100; a = 32'h12345678;
        tick();
        chk("mthi_done", {31'd0, done}, 32'd1);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        op = 3'b101; a = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        chk("mtlo_done", {31'd0, done}, 32'd1);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        tick();
        chk("mt_done_drop", {31'd0, done}, 32'd0);

        // MULT 7 * -3 with an ignored start in the middle
        run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 1'b1, 32'h12345678, n);
        chk("mult_lat", n, mul_lat);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        tick();
        chk("mult_no_restart", {31'd0, busy | done}, 32'd0);

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, n);
        chk("multu_lat", n, mul_lat);
        chk("multu_done", {31'd0, done}, 32'd1);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, n);
        chk("div_lat", n, 33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(3'b011, 32'd100, 32'd0, 1'b0, 32'd0, n);
        chk("divu0_lat", n, 33);
        chk("divu0_done", {31'd0, done}, 32'd1);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00000064);

        run_op(3'b010, 32'hFFFFFFF9, 32'd0, 1'b0, 32'd0, n);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'hFFFFFFF9);

        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, n);
        chk("divovf_lat", n, 33);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);

        run_op(3'b011, 32'd1000, 32'd7, 1'b0, 32'd0, n);
        chk("divu_lo", lo, 32'd142);
        chk("divu_hi", hi, 32'd6);

        // Reserved op is ignored
        tick();
        start = 1'b1; op = 3'b110; a = 32'hDEADBEEF; b = 32'h1;
        tick();
        start = 1'b0;
        chk("rsv_done", {31'd0, done}, 32'd0);
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        chk("rsv_hi", hi, 32'd6);
        chk("rsv_lo", lo, 32'd142);

        // Reset at iteration 10 of a DIVU
        start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        tick();
        chk("midrst_no_done", {31'd0, done | busy}, 32'd0);

        // Back-to-back: second op issued in the done cycle of the first
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("b2b1_lat", n, mul_lat);
        chk("b2b1_done", {31'd0, done}, 32'd1);
        chk("b2b1_lo", lo, 32'd15);
        start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("b2b2_lat", n, mul_lat);
        chk("b2b2_done", {31'd0, done}, 32'd1);
        chk("b2b2_hi", hi, 32'd0);
        chk("b2b2_lo", lo, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
